// File: rtl/n_bit_counter_pkg.sv
// n_bit_counter_pkg: shared mode/direction encodings for the step counter
package n_bit_counter_pkg;
    typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} count_mode_e;
    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;
endpackage

// File: rtl/step_next.sv
// step_next: next count value and wrap/saturate event for one up or down step
module step_next
    import n_bit_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MAX   = 2**WIDTH-1
) (
    input  logic [WIDTH-1:0] i_f,
    input  logic [WIDTH-1:0] i_s,
    input  logic             i_up,
    input  logic             i_sat,
    output logic [WIDTH-1:0] o_next,
    output logic             o_evt
);
    // One extra bit keeps MAX+1 and F+s representable even when MAX = 2**WIDTH-1
    localparam logic [WIDTH:0]   L_MAX  = (WIDTH+1)'(MAX);
    localparam logic [WIDTH:0]   L_MOD  = (WIDTH+1)'(MAX+1);
    localparam logic [WIDTH-1:0] L_MAXW = WIDTH'(MAX);
    logic [WIDTH:0] w_f, w_s, w_sum;
    logic           w_up_ovf, w_dn_ovf, w_sat;
    assign w_f      = {1'b0, i_f};
    assign w_s      = {1'b0, i_s};
    assign w_sum    = w_f + w_s;
    assign w_up_ovf = w_sum > L_MAX;
    assign w_dn_ovf = w_s > w_f;
    assign w_sat    = count_mode_e'(i_sat) == MODE_SAT;
    assign o_evt    = (i_up == DIR_UP) ? w_up_ovf : w_dn_ovf;
    assign o_next   = (i_up == DIR_UP)
                    ? (!w_up_ovf ? i_f + i_s : w_sat ? L_MAXW : WIDTH'(w_sum - L_MOD))
                    : (!w_dn_ovf ? i_f - i_s : w_sat ? '0 : WIDTH'(w_f + L_MOD - w_s));
endmodule

// File: rtl/n_bit_step_counter.sv
// n_bit_step_counter: up/down modulo-(MAX+1) counter with programmable step,
// load, wrap/saturate modes, carry/borrow pulse and sticky overflow flag
module n_bit_step_counter
    import n_bit_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MAX   = 2**WIDTH-1
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_up,
    input  logic [WIDTH-1:0] i_step,
    input  logic             i_sat,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_ovf_clr,
    output logic [WIDTH-1:0] o_f,
    output logic             o_cout,
    output logic             o_tc,
    output logic             o_ovf
);
    localparam logic [WIDTH-1:0] L_MAX = WIDTH'(MAX);
    logic [WIDTH-1:0] r_f, w_s, w_ld, w_next;
    logic             r_cout, r_ovf, w_evt, w_set;
    assign w_s   = (i_step > L_MAX) ? L_MAX : i_step;
    assign w_ld  = (i_load_val > L_MAX) ? L_MAX : i_load_val;
    assign w_set = !i_load && i_en && w_evt;
    step_next #(.WIDTH(WIDTH), .MAX(MAX)) u_step (
        .i_f    (r_f),
        .i_s    (w_s),
        .i_up   (i_up),
        .i_sat  (i_sat),
        .o_next (w_next),
        .o_evt  (w_evt)
    );
    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_f    <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_f    <= i_load ? w_ld : i_en ? w_next : r_f;
            r_cout <= w_set;
            r_ovf  <= w_set | (r_ovf & !i_ovf_clr);
        end
    end
    assign o_f    = r_f;
    assign o_cout = r_cout;
    assign o_ovf  = r_ovf;
    assign o_tc   = (i_up == DIR_UP) ? (r_f == L_MAX) : (r_f == '0);
endmodule

// File: tb/tb_n_bit_step_counter.sv
// tb_n_bit_step_counter: scoreboard bench with a behavioural reference model
module tb_n_bit_step_counter;
    localparam int W = 4;
    localparam int M = 9;
    logic         clk = 1'b0, clr = 1'b1, en = 1'b0, up = 1'b0, sat = 1'b0, load = 1'b0, oclr = 1'b0;
    logic [W-1:0] st = '0, lv = '0;
    logic [W-1:0] o_f;
    logic         o_cout, o_tc, o_ovf;
    typedef struct {int f; int c; int o; int t;} exp_t;
    exp_t q[$];
    int n_cmp = 0, n_bad = 0;
    int m_f = 0, m_o = 0;

    n_bit_step_counter #(.WIDTH(W), .MAX(M)) dut (
        .i_clk(clk), .i_clr(clr), .i_en(en), .i_up(up), .i_step(st), .i_sat(sat),
        .i_load(load), .i_load_val(lv), .i_ovf_clr(oclr),
        .o_f(o_f), .o_cout(o_cout), .o_tc(o_tc), .o_ovf(o_ovf)
    );

    always #5 clk = ~clk;

    task automatic cmp(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue the reference outcome
    task automatic drive(bit c, bit ld, int v, bit e, bit u, int s, bit sa, bit oc);
        int ss, t, ev;
        @(negedge clk);
        clr = c; load = ld; lv = W'(v); en = e; up = u; st = W'(s); sat = sa; oclr = oc;
        ss = (s > M) ? M : s;
        ev = 0;
        if (c) begin
            m_f = 0;
            m_o = 0;
        end else begin
            if (ld) m_f = (v > M) ? M : v;
            else if (e && u) begin
                t = m_f + ss;
                if (t > M) begin ev = 1; m_f = sa ? M : t - (M + 1); end
                else m_f = t;
            end else if (e) begin
                t = m_f - ss;
                if (t < 0) begin ev = 1; m_f = sa ? 0 : t + (M + 1); end
                else m_f = t;
            end
            m_o = (ev || (m_o && !oc)) ? 1 : 0;
        end
        q.push_back('{m_f, ev, m_o, u ? int'(m_f == M) : int'(m_f == 0)});
    endtask

    task automatic now(string nm, int f, int c, int o, int t);
        @(posedge clk);
        #2;
        cmp({nm, ".f"}, int'(o_f), f);
        cmp({nm, ".cout"}, int'(o_cout), c);
        cmp({nm, ".ovf"}, int'(o_ovf), o);
        cmp({nm, ".tc"}, int'(o_tc), t);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp("sb.f", int'(o_f), e.f);
                cmp("sb.cout", int'(o_cout), e.c);
                cmp("sb.ovf", int'(o_ovf), e.o);
                cmp("sb.tc", int'(o_tc), e.t);
            end
        end
    end

    initial begin : stim
        #1;
        cmp("reset.f", int'(o_f), 0);
        cmp("reset.cout", int'(o_cout), 0);
        cmp("reset.ovf", int'(o_ovf), 0);
        drive(1, 0, 0, 1, 1, 3, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        // Mid-count asynchronous clear
        drive(0, 1, 6, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 1, 4, 0, 0);
        now("wrap_pre", 0, 1, 1, 0);
        #1;
        clr = 1'b1;
        #1;
        cmp("async_clr.f", int'(o_f), 0);
        cmp("async_clr.cout", int'(o_cout), 0);
        cmp("async_clr.ovf", int'(o_ovf), 0);
        m_f = 0; m_o = 0;
        drive(1, 0, 0, 1, 1, 3, 0, 0);
        drive(1, 1, 5, 1, 1, 3, 0, 0);
        now("held_clr", 0, 0, 0, 0);
        // Wrap up from 8 by 3
        drive(0, 1, 8, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 1, 3, 0, 0);
        now("wrap_up", 1, 1, 1, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        now("wrap_up_hold", 1, 0, 1, 0);
        // Saturate down from 2 by 5, then held saturation
        drive(0, 1, 2, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0, 5, 1, 0);
        now("sat_down", 0, 1, 1, 1);
        drive(0, 0, 0, 1, 0, 5, 1, 0);
        now("sat_down_again", 0, 1, 1, 1);
        // Load has priority over enable and is clamped to MAX
        drive(0, 1, 14, 1, 1, 3, 0, 0);
        now("load_clamp", 9, 0, 1, 1);
        // Step clamp and wrap down: 3 + 10 - 9
        drive(0, 1, 3, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 15, 0, 0);
        now("step_clamp", 4, 1, 1, 0);
        // Set wins over clear on the same edge
        drive(0, 1, 8, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 1, 3, 0, 1);
        now("ovf_race", 1, 1, 1, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 1);
        now("ovf_clear", 1, 0, 0, 0);
        // Zero step: no movement, no event
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        now("zero_step", 1, 0, 0, 0);
        for (int i = 0; i < 400; i++)
            drive(0, $urandom_range(7) == 0, $urandom_range(15), $urandom_range(3) != 0,
                  $urandom_range(1) == 1, $urandom_range(15), $urandom_range(1) == 1,
                  $urandom_range(7) == 0);
        repeat (2) @(posedge clk);
        #2;
        cmp("sb.drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
